dff_pipeline: RTL
=================

# dff_pipeline

Parametrised delay line built from a chain of D flip-flop stages. It carries a WIDTH-bit data word and a per-stage valid bit through DEPTH stages, with a global stall enable, a synchronous flush and an occupancy count. It replaces the single-bit flip-flop wherever the design needs a retiming register, a fixed-latency alignment delay or a stallable pipeline stage.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 4, number of register stages, equal to the latency in enabled cycles (>= 1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset or flush

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- en  input  1  shift enable; 0 = all stages hold
- clr  input  1  synchronous flush; has priority over en
- in_valid  input  1  valid qualifier for in
- in  input  WIDTH  data into stage 0
- out_valid  output  1  valid bit of the last stage (DEPTH-1)
- out  output  WIDTH  data of the last stage (DEPTH-1)
- count  output  $clog2(DEPTH+1)  number of stages currently holding valid data

## Operation
- Storage: data stage d[0..DEPTH-1], valid stage v[0..DEPTH-1], registered count.
- rst=0 (asynchronous, any time): all d = RST_VAL, all v = 0, count = 0. This takes effect immediately, without waiting for a clock edge, and holds while rst=0.
- Per rising clk edge with rst=1, in priority order:
  - clr=1: all d = RST_VAL, all v = 0, count = 0. en, in and in_valid are ignored on that edge.
  - en=1: d[0]<=in, v[0]<=in_valid, and d[k]<=d[k-1], v[k]<=v[k-1] for k=1..DEPTH-1. count <= count + in_valid - v[DEPTH-1].
  - en=0: every register holds, including count.
- Data shifts whether or not its valid bit is set. When out_valid=0, out is not gated and shows whatever word sits in the last stage.
- count always equals the popcount of v, is never above DEPTH and never wraps. A simultaneous entry (in_valid=1) and exit (v[DEPTH-1]=1) leaves count unchanged.
- out = d[DEPTH-1] and out_valid = v[DEPTH-1]. Both come directly from flops, with no combinational path from the inputs.
- DEPTH=1 reduces the block to a single flip-flop with enable, flush and valid; count is then 1 bit.

## Timing
- Latency: a word presented with en=1 at edge N appears on out after edge N+DEPTH-1, provided en stays 1 on the intervening edges. Each en=0 edge adds exactly one cycle of delay.
- Throughput: one word per enabled cycle, with no bubbles inserted.
- Inputs are sampled only on the rising clk edge. Outputs change only on a rising edge or when rst is asserted.
- When rst is released (0->1), the first edge that can act is the next rising edge. The design must meet the usual recovery timing.
- If reset is asserted while the pipeline is mid-stream, all in-flight words are lost. Nothing is replayed after release.
- If clr and en are both 1 on the same edge, the flush wins and the input word is dropped.
- Outputs after reset: out=RST_VAL, out_valid=0, count=0.

## Test plan
All scenarios use WIDTH=8, DEPTH=3, RST_VAL=8'hA5.
- Reset: hold rst=0 for 2 edges, then release -> out=8'hA5, out_valid=0, count=0. Assert rst=0 between clock edges -> outputs return to these values without waiting for an edge.
- Streaming: en=1, in_valid=1, in=8'h01,02,03,04 on consecutive edges -> out=8'h01 with out_valid=1 after the 3rd edge, then 02, 03, 04 on the following edges. count goes 1,2,3 and then stays at 3.
- Stall: stream 8'h10,8'h11, hold en=0 for 2 edges, then resume -> out and count frozen during the stall. 8'h10 reaches out 2 edges later than it would without the stall.
- Bubbles: in_valid pattern 1,0,1 with data 8'h20,8'hFF,8'h22 -> out_valid pattern 1,0,1 after 3 edges, and out=8'hFF appears while out_valid=0. count never exceeds 2.
- Flush priority: with 3 valid words in the pipe, apply clr=1, en=1, in=8'h77, in_valid=1 on the same edge -> next cycle out=8'hA5, out_valid=0, count=0, and 8'h77 never appears.
- Reset mid-stream: drop rst=0 halfway between edges while count=2 -> count=0 and out=8'hA5 immediately. After release, a fresh stream behaves as in the streaming scenario.

Source files
------------

// File: rtl/dff_pipeline.sv
// ---------------------------------------------------------------------------
// dff_pipeline
//
// Parametrised delay line built from a chain of D flip-flop stages. A WIDTH-bit
// data word and a per-stage valid bit move through DEPTH stages together. The
// chain can be stalled globally, flushed synchronously and reports how many
// stages currently hold valid data. Typical uses are retiming registers,
// fixed-latency alignment delays and stallable pipeline stages.
//
// Parameters:
//   WIDTH    data word width in bits (>= 1)
//   DEPTH    number of register stages, equal to the latency in enabled cycles
//   RST_VAL  value loaded into every data stage on reset or flush
//
// Ports:
//   clk        in   1                  rising-edge clock
//   rst        in   1                  asynchronous reset, active low
//   en         in   1                  shift enable, 0 holds every register
//   clr        in   1                  synchronous flush, wins over en
//   in_valid   in   1                  valid qualifier for in
//   in         in   WIDTH              data into stage 0
//   out_valid  out  1                  valid bit of the last stage
//   out        out  WIDTH              data of the last stage
//   count      out  $clog2(DEPTH+1)    number of stages holding valid data
// ---------------------------------------------------------------------------
module dff_pipeline #(
    parameter int                WIDTH   = 8,
    parameter int                DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Next-state for the whole chain. Flush beats enable; with neither, every
    // register keeps its value. Data moves regardless of its valid bit so the
    // last stage always shows whatever word reached it.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
        end
        valid_d = valid_q;
        count_d = count_q;

        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = RST_VAL;
            end
            valid_d = '0;
            count_d = '0;
        end else if (en) begin
            data_d[0]  = in;
            valid_d[0] = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end

            // Occupancy tracks the popcount of the valid bits: one in, one out
            // cancel, so the counter can never exceed DEPTH or wrap.
            case ({in_valid, valid_q[DEPTH-1]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers. Reset acts asynchronously so in-flight words are
    // discarded immediately, not on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RST_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from flops; no combinational path from inputs.
    assign out       = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign count     = count_q;

endmodule
